// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Valid/ready handshake bundle shared by the upstream and
//               downstream sides of one pipeline stage boundary.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // master drives the stage (upstream producer plus downstream consumer)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline-stage register with 2-entry skid buffer, stall,
//               flush and a saturating count of flushed entries.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 8
) (
    input  wire logic             Clk,
    input  wire logic             Rst,
    pipe_stage_skid_if.slave      bus,
    input  wire logic             Stall,
    input  wire logic             Flush,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      drop_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef logic [CNT_W+1:0] sum_t;
    localparam sum_t c_cnt_max = sum_t'({CNT_W{1'b1}});

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_head_from_in;
    logic              w_head_from_skid;
    logic              w_skid_from_in;
    sum_t              w_drop_sum;
    logic [CNT_W-1:0]  w_drop_next;

    // Handshake flags come from registered state only
    assign w_in_ready  = (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready & ~Stall;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_head;
    assign occupancy     = r_state;
    assign drop_cnt      = r_drop_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_head_from_in = 1'b1;
                    w_state_next   = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_head_from_in = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_from_in = 1'b1;
                    w_state_next   = S_FULL;
                end else if (w_out_fire) begin
                    w_state_next   = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_head_from_skid = 1'b1;
                    w_state_next     = S_ONE;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
        if (Flush) begin
            w_state_next = S_EMPTY;
        end
    end

    // Never negative: an out_fire always has a held entry to cancel against
    assign w_drop_sum  = sum_t'(r_drop_cnt) + sum_t'(occupancy)
                       + sum_t'(w_in_fire) - sum_t'(w_out_fire);
    assign w_drop_next = (w_drop_sum > c_cnt_max) ? {CNT_W{1'b1}}
                                                  : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_head     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_drop_cnt <= '0;
        end else if (Flush) begin
            r_head     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_drop_cnt <= w_drop_next;
        end else begin
            if (w_head_from_in) begin
                r_head <= bus.in_data;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= bus.in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed and randomized checks of pipe_stage_skid against a
//               queue-based model; a second instance has a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int             DW    = 16;
    localparam logic [DW-1:0]  BUB_B = 16'hDEAD;

    logic          Clk       = 1'b0;
    logic          Rst       = 1'b1;
    logic          Stall     = 1'b0;
    logic          Flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;

    logic [1:0]    occ_a;
    logic [1:0]    occ_b;
    logic [7:0]    drop_a;
    logic [1:0]    drop_b;

    pipe_stage_skid_if #(.DATA_W(DW)) bus_a ();
    pipe_stage_skid_if #(.DATA_W(DW)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE('0), .CNT_W(8)) u_dut_a (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus_a),
        .Stall     (Stall),
        .Flush     (Flush),
        .occupancy (occ_a),
        .drop_cnt  (drop_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB_B), .CNT_W(2)) u_dut_b (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus_b),
        .Stall     (Stall),
        .Flush     (Flush),
        .occupancy (occ_b),
        .drop_cnt  (drop_b)
    );

    always #5 Clk = ~Clk;

    // Reference model: FIFO of held entries plus what an empty stage shows
    logic [DW-1:0] q[$];
    int            m_drop_a;
    int            m_drop_b;
    logic [DW-1:0] m_stale;
    bit            m_stale_bub;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drop_a    = 0;
        m_drop_b    = 0;
        m_stale     = '0;
        m_stale_bub = 1'b1;
    endtask

    task automatic model_edge();
        bit inf;
        bit outf;
        int d;
        inf  = in_valid && (q.size() < 2);
        outf = (q.size() > 0) && out_ready && !Stall;
        if (Flush) begin
            d = q.size() + int'(inf) - int'(outf);
            m_drop_a    = (m_drop_a + d > 255) ? 255 : m_drop_a + d;
            m_drop_b    = (m_drop_b + d > 3) ? 3 : m_drop_b + d;
            q.delete();
            m_stale_bub = 1'b1;
        end else begin
            if (outf) begin
                m_stale     = q.pop_front();
                m_stale_bub = 1'b0;
            end
            if (inf) q.push_back(in_data);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        exp_a = (q.size() > 0) ? q[0] : (m_stale_bub ? '0    : m_stale);
        exp_b = (q.size() > 0) ? q[0] : (m_stale_bub ? BUB_B : m_stale);
        check("in_ready",   bus_a.in_ready,  q.size() < 2);
        check("out_valid",  bus_a.out_valid, q.size() > 0);
        check("out_data",   bus_a.out_data,  exp_a);
        check("occupancy",  occ_a,           q.size());
        check("drop_cnt",   drop_a,          m_drop_a);
        check("out_data_b", bus_b.out_data,  exp_b);
        check("drop_cnt_b", drop_b,          m_drop_b);
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                        input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        Stall     = st;
        Flush     = fl;
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset lands mid-cycle and must act before any clock edge
    task automatic reset_async();
        #2;
        Rst = 1'b1;
        #1;
        check("rst_out_valid", bus_a.out_valid, 1'b0);
        check("rst_in_ready",  bus_a.in_ready,  1'b1);
        check("rst_out_data",  bus_a.out_data,  '0);
        check("rst_occ",       occ_a,           2'd0);
        check("rst_drop",      drop_a,          8'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("init_out_data_b", bus_b.out_data, BUB_B);
        Rst = 1'b0;
        check_all();

        // Fill the stage, then reset mid-cycle with it FULL
        step(1, 16'h00F1, 0, 0, 0);
        step(1, 16'h00F2, 0, 0, 0);
        check("full_occ", occ_a, 2'd2);
        reset_async();

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            step(1, DW'(i), 1, 0, 0);
            check("stream_data", bus_a.out_data, i);
        end
        step(0, '0, 1, 0, 0);

        // Backpressure
        step(1, 16'h000A, 0, 0, 0);
        step(1, 16'h000B, 0, 0, 0);
        step(1, 16'h000C, 0, 0, 0);
        check("bp_occ",      occ_a,          2'd2);
        check("bp_in_ready", bus_a.in_ready, 1'b0);
        check("bp_head",     bus_a.out_data, 16'h000A);
        step(1, 16'h000C, 1, 0, 0);
        step(1, 16'h000C, 1, 0, 0);
        step(0, '0, 1, 0, 0);

        // Stall
        step(1, 16'h0011, 1, 1, 0);
        step(1, 16'h0022, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        check("stall_hold",     bus_a.out_data, 16'h0011);
        check("stall_in_ready", bus_a.in_ready, 1'b0);
        repeat (3) step(0, '0, 1, 0, 0);

        // Flush from FULL, then flush with concurrent intake, then saturation
        step(1, 16'h0005, 0, 0, 0);
        step(1, 16'h0006, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        check("flush_valid",  bus_a.out_valid, 1'b0);
        check("flush_bubble", bus_a.out_data,  '0);
        check("flush_drop",   drop_a,          8'd2);
        check("sat_drop_1",   drop_b,          2'd2);
        step(1, 16'h0009, 0, 0, 0);
        step(1, 16'h0007, 0, 0, 1);
        check("flush_in_drop", drop_a,          8'd4);
        check("flush_in_gone", bus_a.out_valid, 1'b0);
        check("sat_drop_2",    drop_b,          2'd3);
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        step(0, '0, 0, 1, 1);
        check("sat_drop_3", drop_b, 2'd3);
        check("drop_6",     drop_a, 8'd6);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                reset_async();
            end else begin
                step($urandom_range(3) != 0, DW'($urandom),
                     $urandom_range(3) != 0, $urandom_range(3) == 0,
                     $urandom_range(19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register, the generalised successor to the fixed-format instruction latch between pipeline stages. It carries an opaque payload of DATA_W bits from an upstream stage to a downstream stage with a valid/ready handshake, and adds a 2-entry skid buffer so that `in_ready` depends only on registered state. Stall and flush inputs hold or clear the stage, and a counter reports how many valid entries flushes have discarded. It is instantiated at each stage boundary (IF/ID, ID/EX, …) with per-stage widths.

## Interface
- `DATA_W`, default 64: payload width (for IF/ID this is instruction plus PC_4).
- `BUBBLE`, default all zeros (DATA_W bits): value driven on `out_data` after reset and after flush.
- `CNT_W`, default 8: width of the drop counter.

Ports:
- `Clk` in 1: single clock. All state updates on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream offers `in_data`.
- `in_data` in DATA_W: payload from upstream.
- `in_ready` out 1: stage can accept an entry.
- `out_valid` out 1: `out_data` holds a valid entry.
- `out_data` out DATA_W: head entry, or `BUBBLE` when empty after reset or flush.
- `out_ready` in 1: downstream consumes the head entry.
- `Stall` in 1: freezes the output side.
- `Flush` in 1: synchronous clear of the stage.
- `occupancy` out 2: number of held entries (0, 1 or 2).
- `drop_cnt` out CNT_W: saturating count of entries discarded by flushes.

## Operation
- Storage is two registers: the head (`out_data`) and the skid. Order is FIFO; the head is always the oldest entry.
- States:
  - EMPTY: occupancy 0.
  - ONE: head valid.
  - FULL: head and skid valid.
- Outputs derived from state:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
- Handshake events:
  - `in_fire` = `in_valid` & `in_ready`.
  - `out_fire` = `out_valid` & `out_ready` & !`Stall`.
- `Stall` blocks only `out_fire`. Intake continues while stalled until the stage is FULL.
- Transitions, when `Flush` = 0:
  - EMPTY: on `in_fire`, head <= `in_data`, go to ONE.
  - ONE, `in_fire` & `out_fire`: head <= `in_data`, stay in ONE.
  - ONE, `in_fire` only: skid <= `in_data`, go to FULL.
  - ONE, `out_fire` only: go to EMPTY. Head keeps its stale value; `out_data` is undefined-but-stable when `out_valid` = 0.
  - FULL, `out_fire`: head <= skid, go to ONE. No `in_fire` is possible in FULL.
  - In every state, no event means hold.
- Flush has priority over every other event on the same edge:
  - state <= EMPTY, head <= `BUBBLE`, skid <= `BUBBLE`.
  - A concurrent `in_fire` is dropped. A concurrent `out_fire` still counts as consumed downstream, but the entry is not re-presented.
- Drop counter:
  - On a flush edge, add occupancy + (`in_fire` ? 1 : 0) − (`out_fire` ? 1 : 0).
  - Compute the sum in CNT_W+2 bits, then clamp to 2^CNT_W − 1.
  - Once saturated, the counter stays saturated until reset.
- `Flush` and `Stall` high together: flush wins.

## Timing
- Reset values, while `Rst` is high and immediately after it falls:
  - state EMPTY, `in_ready` = 1, `out_valid` = 0.
  - `out_data` = `BUBBLE`, skid = `BUBBLE`.
  - `occupancy` = 0, `drop_cnt` = 0.
- Reset mid-transfer discards all entries without counting them.
- Latency: an entry accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N, provided the stage was EMPTY or the head was consumed at N.
- Throughput is 1 entry per cycle while `out_ready` = 1 and `Stall` = 0.
- `in_ready` falls the cycle after the skid fills. It rises on the edge where FULL drains to ONE.
- `in_ready`, `out_valid` and `occupancy` are functions of registered state only. There is no combinational path from `out_ready`, `Stall` or `Flush` to `in_ready`.
- `out_data` must not change while `out_valid` = 1 and `out_fire` = 0, except on flush.

## Test plan
- Reset: assert `Rst` asynchronously mid-cycle with the stage FULL. Required: immediately `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `occupancy` = 0, `drop_cnt` = 0.
- Streaming: `out_ready` = 1 and 8 back-to-back entries 0x1…0x8. Required: `out_data` shows 0x1…0x8 on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Backpressure: with `out_ready` = 0, push 0xA, 0xB, 0xC. Required: 0xA and 0xB are accepted, `in_ready` = 0 while 0xC is offered, `occupancy` = 2. Raising `out_ready` yields 0xA, 0xB, 0xC in order.
- Stall: with `out_ready` = 1 and `Stall` = 1 for 3 cycles, offer 0x11, 0x22. Required: `out_data` holds 0x11 and `in_ready` drops. After `Stall` falls, 0x11 then 0x22 are delivered with no loss or duplication.
- Flush with concurrent input: with the stage FULL (0x5, 0x6) and `out_ready` = 0, assert `Flush` with `in_valid` = 0. Required: next cycle `out_valid` = 0, `out_data` = `BUBBLE`, `drop_cnt` = 2. Then from ONE, flush together with a 0x7 `in_fire`: required `drop_cnt` = 4 and 0x7 is never output.
- Saturation: with CNT_W = 2, issue repeated FULL flushes. Required: `drop_cnt` goes 2, then 3, then stays at 3.
